// File: rtl/branch_cond_eval_pkg.sv
// Shared branch-condition constants, FSM encoding and the
// combinational condition evaluator used by decode and branch units.
package branch_pkg;

  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_HOLD = 2'd1;
  localparam logic [1:0] ENC_EVAL = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_HOLD = ENC_HOLD,
    ST_EVAL = ENC_EVAL,
    ST_DONE = ENC_DONE
  } state_t;

  function automatic logic cond_eval(
    input logic [3:0] cond,
    input logic       n,
    input logic       z,
    input logic       v,
    input logic       c
  );
    logic t;
    t = 1'b0;
    unique case (cond)
      COND_BN:   t = 1'b0;
      COND_BE:   t = z;
      COND_BLE:  t = z | (n ^ v);
      COND_BL:   t = n ^ v;
      COND_BLEU: t = c | z;
      COND_BCS:  t = c;
      COND_BNEG: t = n;
      COND_BVS:  t = v;
      COND_BA:   t = 1'b1;
      COND_BNE:  t = ~z;
      COND_BG:   t = ~(z | (n ^ v));
      COND_BGE:  t = ~(n ^ v);
      COND_BGU:  t = ~(c | z);
      COND_BCC:  t = ~c;
      COND_BPOS: t = ~n;
      COND_BVC:  t = ~v;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_cond_eval_if.sv
// Request/acknowledge bundle between the control unit's
// branch sequencer and the condition evaluator.
interface branch_cond_eval_if;
  import branch_pkg::*;

  logic       req;
  logic [3:0] cond;
  logic       busy;
  logic       ack;
  logic       taken;
  logic       err;

  modport master (
    output req, cond,
    input  busy, ack, taken, err
  );

  modport slave (
    input  req, cond,
    output busy, ack, taken, err
  );

endinterface

// File: rtl/branch_cond_eval_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + W'(1);
  end

endmodule

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: waits out in-flight cc updates,
// samples PSR flags, returns a registered decision with ack.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  branch_cond_eval_if.slave bus,
  input  logic             nin,
  input  logic             zin,
  input  logic             vin,
  input  logic             cin,
  input  logic             cc_pending,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state;
  logic [3:0] cond_q;
  logic [7:0] hold_cnt;
  logic       eval_inc;
  logic       taken_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cond_q    <= 4'h0;
      hold_cnt  <= 8'd0;
      bus.busy  <= 1'b0;
      bus.ack   <= 1'b0;
      bus.taken <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req) begin
            cond_q   <= bus.cond;
            hold_cnt <= 8'd0;
            bus.busy <= 1'b1;
            state    <= cc_pending ? ST_HOLD : ST_EVAL;
          end
        end
        ST_HOLD: begin
          // a flag drop wins over a timeout on the same cycle
          if (!cc_pending) begin
            state <= ST_EVAL;
          end else if (hold_cnt == HOLD_LIM) begin
            bus.ack   <= 1'b1;
            bus.err   <= 1'b1;
            bus.taken <= 1'b0;
            state     <= ST_DONE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_EVAL: begin
          bus.taken <= cond_eval(cond_q, nin, zin, vin, cin);
          bus.err   <= 1'b0;
          bus.ack   <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign eval_inc  = (state == ST_DONE) && !bus.err;
  assign taken_inc = (state == ST_DONE) && bus.taken;

  sat_counter #(.W(CNT_W)) u_eval_cnt (
    .clk (clk),
    .clr (rst),
    .inc (eval_inc),
    .q   (eval_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .clr (rst),
    .inc (taken_inc),
    .q   (taken_cnt)
  );

endmodule
